// File: rtl/stencil_linebuf_ub_if.sv
// Stream interface for the stencil line-buffer unit.
//   master side (pixel producer): drives flush, in_wen, in_data and
//                                 observes the window outputs.
//   slave side  (the buffer)    : receives pixels, drives out_valid,
//                                 out_data (K*K taps), out_x, out_y,
//                                 frame_done.
interface stencil_linebuf_ub_if #(
  parameter int DATA_W = 16,
  parameter int K      = 3,
  parameter int XW     = 6,
  parameter int YW     = 6
);
  logic                    flush;
  logic                    in_wen;
  logic [DATA_W-1:0]       in_data;
  logic                    out_valid;
  logic [K*K*DATA_W-1:0]   out_data;
  logic [XW-1:0]           out_x;
  logic [YW-1:0]           out_y;
  logic                    frame_done;

  modport master (
    output flush, in_wen, in_data,
    input  out_valid, out_data, out_x, out_y, frame_done
  );

  modport slave (
    input  flush, in_wen, in_data,
    output out_valid, out_data, out_x, out_y, frame_done
  );
endinterface

// File: rtl/stencil_linebuf_ub.sv
// Streaming unified buffer producing a full KxK stencil window for every
// accepted raster-order pixel. K-1 previous image rows live in ring line
// buffers indexed by the internal column counter; the window itself is a
// KxK column shift register.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (counters and outputs)
//   bus    - slave modport: flush / in_wen / in_data in,
//            out_valid / out_data / out_x / out_y / frame_done out.
//            Tap t = r*K+c of out_data holds pixel (out_x+c, out_y+r).
module stencil_linebuf_ub #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int K      = 3,
  parameter int XW     = $clog2(IMG_W),
  parameter int YW     = $clog2(IMG_H)
) (
  input  logic                clk,
  input  logic                rst_n,
  stencil_linebuf_ub_if.slave bus
);

  localparam int WIN_W = K * K * DATA_W;

  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_FIRST = XW'(K - 1);
  localparam logic [YW-1:0] Y_FIRST = YW'(K - 1);

  // Line buffer storage: lb_mem[j][x] holds row y-1-j at column x.
  logic [DATA_W-1:0] lb_mem [K-1][IMG_W];

  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              out_valid_q, out_valid_d;
  logic [WIN_W-1:0]  out_data_q, out_data_d;
  logic [XW-1:0]     out_x_q, out_x_d;
  logic [YW-1:0]     out_y_q, out_y_d;
  logic              frame_done_q, frame_done_d;

  logic [DATA_W-1:0] col [K];
  logic              accept;

  // flush takes priority over a coincident write; that pixel is dropped.
  assign accept = bus.in_wen && !bus.flush;

  // Column entering the window: oldest row at the top, live pixel at the bottom.
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      col[r] = lb_mem[K-2-r][x_q];
    end
    col[K-1] = bus.in_data;
  end

  // The registered output window doubles as the window shift register:
  // both change only on an accepted write, so a separate copy would be
  // redundant.
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    out_data_d   = out_data_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;

    if (bus.flush) begin
      x_d = '0;
      y_d = '0;
    end else if (bus.in_wen) begin
      // Shifting the flat vector down one tap moves every column left;
      // the rightmost tap of each row then receives the new column,
      // overwriting the value that leaked in from the next row.
      out_data_d = out_data_q >> DATA_W;
      for (int r = 0; r < K; r++) begin
        out_data_d[(r*K + K-1)*DATA_W +: DATA_W] = col[r];
      end

      // Windows that would straddle a row or frame boundary never
      // qualify, so stale window or line-buffer data is never exposed.
      out_valid_d  = (x_q >= X_FIRST) && (y_q >= Y_FIRST);
      out_x_d      = x_q - X_FIRST;
      out_y_d      = y_q - Y_FIRST;
      frame_done_d = (x_q == X_LAST) && (y_q == Y_LAST);

      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q          <= '0;
      y_q          <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffers: combinational read above, registered write here. Each
  // buffer reads and writes the same column in a cycle, so the read sees
  // the old contents and rows ripple down one buffer per write.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_mem[0][x_q] <= bus.in_data;
      for (int j = 1; j < K - 1; j++) begin
        lb_mem[j][x_q] <= lb_mem[j-1][x_q];
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_x      = out_x_q;
  assign bus.out_y      = out_y_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_stencil_linebuf_ub.sv
// Self-checking bench for stencil_linebuf_ub. Two instances: an 8x6 K=3
// unit (A) and an 8x8 K=5 unit (B). A frame-store reference model pushes
// expected windows to per-instance queues as pixels are driven; monitors
// pop and compare whenever out_valid is seen.
module tb_stencil_linebuf_ub;

  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int AH   = 6;
  localparam int AK   = 3;
  localparam int BW   = 8;
  localparam int BH   = 8;
  localparam int BK   = 5;
  localparam int MAXW = 400;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stencil_linebuf_ub_if #(.DATA_W(DW), .K(AK), .XW(3), .YW(3)) ia ();
  stencil_linebuf_ub_if #(.DATA_W(DW), .K(BK), .XW(3), .YW(3)) ib ();

  stencil_linebuf_ub #(.DATA_W(DW), .IMG_W(AW), .IMG_H(AH), .K(AK)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia));
  stencil_linebuf_ub #(.DATA_W(DW), .IMG_W(BW), .IMG_H(BH), .K(BK)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib));

  int n_checks = 0;
  int n_errors = 0;

  int img_a [AH][AW];
  int img_b [BH][BW];
  int ax = 0, ay = 0, bx = 0, by = 0;
  logic [MAXW-1:0] qa_d [$];
  int              qa_x [$];
  int              qa_y [$];
  logic [MAXW-1:0] qb_d [$];
  int              qb_x [$];
  int              qb_y [$];

  int   va_cnt = 0, fda_cnt = 0, vb_cnt = 0, fdb_cnt = 0, vb_xmax = 0;
  logic a_last_acc = 1'b0, b_last_acc = 1'b0;

  initial begin
    ia.flush = 1'b0; ia.in_wen = 1'b0; ia.in_data = '0;
    ib.flush = 1'b0; ib.in_wen = 1'b0; ib.in_data = '0;
  end

  // Drive one cycle on A and advance its reference model.
  task automatic step_a(input logic wen, input logic fl, input int pix);
    logic [MAXW-1:0] w;
    ia.in_wen  = wen;
    ia.flush   = fl;
    ia.in_data = DW'(pix);
    if (fl) begin
      ax = 0; ay = 0;
    end else if (wen) begin
      img_a[ay][ax] = pix;
      if (ax >= AK-1 && ay >= AK-1) begin
        w = '0;
        for (int r = 0; r < AK; r++)
          for (int c = 0; c < AK; c++)
            w[(r*AK+c)*DW +: DW] = DW'(img_a[ay-AK+1+r][ax-AK+1+c]);
        qa_d.push_back(w); qa_x.push_back(ax-AK+1); qa_y.push_back(ay-AK+1);
      end
      ax++;
      if (ax == AW) begin ax = 0; ay++; if (ay == AH) ay = 0; end
    end
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic wen, input int pix);
    logic [MAXW-1:0] w;
    ib.in_wen  = wen;
    ib.in_data = DW'(pix);
    if (wen) begin
      img_b[by][bx] = pix;
      if (bx >= BK-1 && by >= BK-1) begin
        w = '0;
        for (int r = 0; r < BK; r++)
          for (int c = 0; c < BK; c++)
            w[(r*BK+c)*DW +: DW] = DW'(img_b[by-BK+1+r][bx-BK+1+c]);
        qb_d.push_back(w); qb_x.push_back(bx-BK+1); qb_y.push_back(by-BK+1);
      end
      bx++;
      if (bx == BW) begin bx = 0; by++; if (by == BH) by = 0; end
    end
    @(posedge clk); #1;
  endtask

  // Scoreboard monitors, sampling on the falling edge.
  always @(negedge clk) begin
    logic [MAXW-1:0] ed, got;
    int ex, ey;
    if (rst_n) begin
      if (ia.out_valid) begin
        va_cnt++;
        n_checks++;
        if (!a_last_acc) begin
          n_errors++;
          $display("FAIL a_valid_after_idle: out_valid=1 required 0");
        end
        n_checks++;
        if (qa_d.size() == 0) begin
          n_errors++;
          $display("FAIL a_sb_unexpected: window x=%0d y=%0d, expected none", ia.out_x, ia.out_y);
        end else begin
          ed = qa_d.pop_front(); ex = qa_x.pop_front(); ey = qa_y.pop_front();
          got = MAXW'(ia.out_data);
          if (got !== ed || ia.out_x !== 3'(ex) || ia.out_y !== 3'(ey)) begin
            n_errors++;
            $display("FAIL a_sb_window: got x=%0d y=%0d d=%h required x=%0d y=%0d d=%h",
                     ia.out_x, ia.out_y, got, ex, ey, ed);
          end
        end
      end
      if (ia.frame_done) fda_cnt++;
      if (ib.out_valid) begin
        vb_cnt++;
        if (int'(ib.out_x) > vb_xmax) vb_xmax = int'(ib.out_x);
        n_checks++;
        if (!b_last_acc) begin
          n_errors++;
          $display("FAIL b_valid_after_idle: out_valid=1 required 0");
        end
        n_checks++;
        if (qb_d.size() == 0) begin
          n_errors++;
          $display("FAIL b_sb_unexpected: window x=%0d y=%0d, expected none", ib.out_x, ib.out_y);
        end else begin
          ed = qb_d.pop_front(); ex = qb_x.pop_front(); ey = qb_y.pop_front();
          got = MAXW'(ib.out_data);
          if (got !== ed || ib.out_x !== 3'(ex) || ib.out_y !== 3'(ey)) begin
            n_errors++;
            $display("FAIL b_sb_window: got x=%0d y=%0d d=%h required x=%0d y=%0d d=%h",
                     ib.out_x, ib.out_y, got, ex, ey, ed);
          end
        end
      end
      if (ib.frame_done) fdb_cnt++;
    end
    a_last_acc = rst_n && ia.in_wen && !ia.flush;
    b_last_acc = rst_n && ib.in_wen;
  end

  function automatic logic [MAXW-1:0] first_win3(input int off);
    int tv [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    logic [MAXW-1:0] e;
    e = '0;
    for (int t = 0; t < 9; t++) e[t*DW +: DW] = DW'(tv[t] + off);
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (ia.out_valid !== 1'b0 || ia.frame_done !== 1'b0 || ia.out_x !== 3'd0 || ia.out_y !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_a_ctrl: valid=%b fd=%b x=%0d y=%0d required all 0",
               ia.out_valid, ia.frame_done, ia.out_x, ia.out_y);
    end
    n_checks++;
    if (ia.out_data !== '0) begin
      n_errors++; $display("FAIL reset_a_data: got %h required 0", ia.out_data);
    end
    n_checks++;
    if (ib.out_valid !== 1'b0 || ib.out_data !== '0 || ib.frame_done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_b: valid=%b fd=%b data=%h required all 0", ib.out_valid, ib.frame_done, ib.out_data);
    end
    rst_n = 1'b1;
    step_a(1'b0, 1'b0, 0);
  endtask

  task automatic test_single_frame();
    va_cnt = 0; fda_cnt = 0;
    for (int i = 0; i < AW*AH; i++) begin
      step_a(1'b1, 1'b0, i);
      if (i == 18) begin
        n_checks++;
        if (va_cnt !== 0 || ia.out_valid !== 1'b1 || ia.out_x !== 3'd0 || ia.out_y !== 3'd0) begin
          n_errors++;
          $display("FAIL first_window_pos: earlier=%0d valid=%b x=%0d y=%0d required 0/1/0/0",
                   va_cnt, ia.out_valid, ia.out_x, ia.out_y);
        end
        n_checks++;
        if (MAXW'(ia.out_data) !== first_win3(0)) begin
          n_errors++;
          $display("FAIL first_window_taps: got %h required %h", ia.out_data, first_win3(0));
        end
      end
    end
    step_a(1'b0, 1'b0, 0);
    n_checks++;
    if (va_cnt !== 24 || fda_cnt !== 1) begin
      n_errors++; $display("FAIL frame_counts: valid=%0d fd=%0d required 24/1", va_cnt, fda_cnt);
    end
    n_checks++;
    if (ia.out_valid !== 1'b0 || ia.frame_done !== 1'b0) begin
      n_errors++; $display("FAIL stall_pulses: valid=%b fd=%b required 0/0", ia.out_valid, ia.frame_done);
    end
    n_checks++;
    if (ia.out_x !== 3'd5 || ia.out_y !== 3'd3 || ia.out_data[8*DW +: DW] !== 16'd47) begin
      n_errors++;
      $display("FAIL last_window_hold: x=%0d y=%0d tap8=%0d required 5/3/47",
               ia.out_x, ia.out_y, ia.out_data[8*DW +: DW]);
    end
  endtask

  task automatic test_gaps();
    va_cnt = 0; fda_cnt = 0;
    for (int i = 0; i < AW*AH; i++) begin
      for (int g = 0; g < 3; g++) begin
        if ($urandom_range(1, 0) == 1) step_a(1'b0, 1'b0, 0);
      end
      step_a(1'b1, 1'b0, i);
    end
    step_a(1'b0, 1'b0, 0);
    n_checks++;
    if (va_cnt !== 24 || fda_cnt !== 1 || qa_d.size() !== 0) begin
      n_errors++;
      $display("FAIL gaps_counts: valid=%0d fd=%0d pending=%0d required 24/1/0", va_cnt, fda_cnt, qa_d.size());
    end
  endtask

  task automatic test_back_to_back();
    va_cnt = 0; fda_cnt = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < AW*AH; i++) begin
        step_a(1'b1, 1'b0, f*100 + i);
        if (f == 1 && i == 18) begin
          n_checks++;
          if (ia.out_valid !== 1'b1 || MAXW'(ia.out_data) !== first_win3(100)) begin
            n_errors++;
            $display("FAIL b2b_frame2_first: valid=%b got %h required %h",
                     ia.out_valid, ia.out_data, first_win3(100));
          end
        end
      end
    end
    step_a(1'b0, 1'b0, 0);
    n_checks++;
    if (va_cnt !== 48 || fda_cnt !== 2 || qa_d.size() !== 0) begin
      n_errors++;
      $display("FAIL b2b_counts: valid=%0d fd=%0d pending=%0d required 48/2/0", va_cnt, fda_cnt, qa_d.size());
    end
  endtask

  task automatic test_flush();
    va_cnt = 0; fda_cnt = 0;
    for (int i = 0; i < 30; i++) step_a(1'b1, 1'b0, i);
    step_a(1'b1, 1'b1, 30);
    n_checks++;
    if (ia.out_valid !== 1'b0 || ia.frame_done !== 1'b0) begin
      n_errors++; $display("FAIL flush_outputs: valid=%b fd=%b required 0/0", ia.out_valid, ia.frame_done);
    end
    for (int n = 1; n <= AW*AH; n++) begin
      step_a(1'b1, 1'b0, n - 1);
      if (n == 18) begin
        n_checks++;
        if (ia.out_valid !== 1'b0) begin
          n_errors++; $display("FAIL flush_early_valid: valid=%b required 0 after 18 writes", ia.out_valid);
        end
      end
      if (n == 19) begin
        n_checks++;
        if (ia.out_valid !== 1'b1 || ia.out_x !== 3'd0 || ia.out_y !== 3'd0 ||
            MAXW'(ia.out_data) !== first_win3(0)) begin
          n_errors++;
          $display("FAIL flush_first_valid: valid=%b x=%0d y=%0d d=%h required 1/0/0/%h",
                   ia.out_valid, ia.out_x, ia.out_y, ia.out_data, first_win3(0));
        end
      end
    end
    step_a(1'b0, 1'b0, 0);
    n_checks++;
    if (va_cnt !== 34 || fda_cnt !== 1 || qa_d.size() !== 0) begin
      n_errors++;
      $display("FAIL flush_counts: valid=%0d fd=%0d pending=%0d required 34/1/0", va_cnt, fda_cnt, qa_d.size());
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 14; i++) step_a(1'b1, 1'b0, i);
    ia.in_wen = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ia.out_valid !== 1'b0 || ia.out_data !== '0 || ia.out_x !== 3'd0 ||
        ia.out_y !== 3'd0 || ia.frame_done !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_outputs: valid=%b x=%0d y=%0d fd=%b d=%h required all 0",
               ia.out_valid, ia.out_x, ia.out_y, ia.frame_done, ia.out_data);
    end
    ax = 0; ay = 0; bx = 0; by = 0;
    qa_d.delete(); qa_x.delete(); qa_y.delete();
    qb_d.delete(); qb_x.delete(); qb_y.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    va_cnt = 0; fda_cnt = 0;
    for (int i = 0; i < AW*AH; i++) begin
      step_a(1'b1, 1'b0, i + 200);
      if (i == 18) begin
        n_checks++;
        if (ia.out_valid !== 1'b1 || ia.out_x !== 3'd0 || ia.out_y !== 3'd0 ||
            MAXW'(ia.out_data) !== first_win3(200)) begin
          n_errors++;
          $display("FAIL midreset_first: valid=%b x=%0d y=%0d d=%h required 1/0/0/%h",
                   ia.out_valid, ia.out_x, ia.out_y, ia.out_data, first_win3(200));
        end
      end
    end
    step_a(1'b0, 1'b0, 0);
    n_checks++;
    if (va_cnt !== 24 || fda_cnt !== 1 || qa_d.size() !== 0) begin
      n_errors++;
      $display("FAIL midreset_counts: valid=%0d fd=%0d pending=%0d required 24/1/0", va_cnt, fda_cnt, qa_d.size());
    end
  endtask

  task automatic test_k5();
    vb_cnt = 0; fdb_cnt = 0; vb_xmax = 0;
    for (int i = 0; i < BW*BH; i++) begin
      step_b(1'b1, i);
      if (i == 36) begin
        n_checks++;
        if (ib.out_valid !== 1'b1 || ib.out_data[24*DW +: DW] !== 16'd36 || ib.out_data[0 +: DW] !== 16'd0) begin
          n_errors++;
          $display("FAIL k5_first: valid=%b tap24=%0d tap0=%0d required 1/36/0",
                   ib.out_valid, ib.out_data[24*DW +: DW], ib.out_data[0 +: DW]);
        end
      end
    end
    step_b(1'b0, 0);
    n_checks++;
    if (vb_cnt !== 16 || fdb_cnt !== 1 || vb_xmax !== 3 || qb_d.size() !== 0) begin
      n_errors++;
      $display("FAIL k5_counts: valid=%0d fd=%0d xmax=%0d pending=%0d required 16/1/3/0",
               vb_cnt, fdb_cnt, vb_xmax, qb_d.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_gaps();
    test_back_to_back();
    test_flush();
    test_reset_midframe();
    test_k5();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
